// File: rtl/vnlp_arbiter.sv
// ---------------------------------------------------------------------------
// vnlp_arbiter
//   Round-robin arbiter that shares one VNLP engine between N_REQ requesters.
//   A granted job is started with a one-cycle pulse, the engine result (or a
//   timeout abort) is captured into shared response registers, and the
//   response is offered to the owner until it is accepted.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   req          per-requester job request (level)
//   grant        one-hot owner of the engine, zero when idle
//   busy         high whenever the arbiter is not idle
//   eng_start    one-cycle engine start pulse
//   eng_done     engine completion, honoured only while waiting for it
//   eng_sum      engine Sum result
//   eng_len      engine Len result
//   rsp_valid    one-hot response valid towards the owner
//   rsp_ready    per-requester response accept
//   rsp_sum      captured Sum result
//   rsp_len      captured Len result
//   rsp_timeout  response corresponds to a timed-out job
// ---------------------------------------------------------------------------
module vnlp_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             eng_start,
  input  logic             eng_done,
  input  logic [27:0]      eng_sum,
  input  logic [8:0]       eng_len,
  output logic [N_REQ-1:0] rsp_valid,
  input  logic [N_REQ-1:0] rsp_ready,
  output logic [27:0]      rsp_sum,
  output logic [8:0]       rsp_len,
  output logic             rsp_timeout
);

  localparam int unsigned SUM_W   = 28;
  localparam int unsigned LEN_W   = 9;
  // Sized for the largest legal TIMEOUT (2047).
  localparam int unsigned TIMER_W = 11;
  localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [PTR_W-1:0]   owner, owner_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [N_REQ-1:0]   grant_next;
  logic               busy_next;
  logic               eng_start_next;
  logic [N_REQ-1:0]   rsp_valid_next;
  logic [SUM_W-1:0]   sum_next;
  logic [LEN_W-1:0]   len_next;
  logic               timeout_next;

  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;

  // Round-robin pick: first asserted request at or after ptr, wrapping.
  always_comb begin
    int unsigned cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(ptr) + i) % N_REQ;
      if (!pick_found && req[PTR_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(cand);
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    owner_next     = owner;
    timer_next     = timer;
    grant_next     = grant;
    sum_next       = rsp_sum;
    len_next       = rsp_len;
    timeout_next   = rsp_timeout;
    eng_start_next = 1'b0;

    case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_next     = S_START;
          owner_next     = pick_idx;
          grant_next     = N_REQ'(1) << pick_idx;
          eng_start_next = 1'b1;
        end
      end

      S_START: begin
        timer_next = '0;
        state_next = S_WAIT;
      end

      S_WAIT: begin
        timer_next = timer + TIMER_W'(1);
        // Completion takes priority over a coincident timeout.
        if (eng_done) begin
          sum_next     = eng_sum;
          len_next     = eng_len;
          timeout_next = 1'b0;
          state_next   = S_RESP;
        end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
          sum_next     = '0;
          len_next     = '0;
          timeout_next = 1'b1;
          state_next   = S_RESP;
        end
      end

      S_RESP: begin
        // Only the owner's ready bit completes the handshake.
        if (rsp_ready[owner]) begin
          ptr_next   = (32'(owner) == N_REQ - 1) ? '0 : owner + PTR_W'(1);
          grant_next = '0;
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
        grant_next = '0;
      end
    endcase

    busy_next      = (state_next != S_IDLE);
    rsp_valid_next = (state_next == S_RESP) ? grant_next : '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      owner       <= '0;
      timer       <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      eng_start   <= 1'b0;
      rsp_valid   <= '0;
      rsp_sum     <= '0;
      rsp_len     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      owner       <= owner_next;
      timer       <= timer_next;
      grant       <= grant_next;
      busy        <= busy_next;
      eng_start   <= eng_start_next;
      rsp_valid   <= rsp_valid_next;
      rsp_sum     <= sum_next;
      rsp_len     <= len_next;
      rsp_timeout <= timeout_next;
    end
  end

endmodule

// File: tb/tb_vnlp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vnlp_arbiter
//   Self-checking bench for vnlp_arbiter (N_REQ=4, TIMEOUT=8): a table of
//   job records with hand-derived expectations, a reset-mid-job sequence,
//   and randomized jobs checked against a round-robin/timeout model.
// ---------------------------------------------------------------------------
module tb_vnlp_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         busy;
  logic         eng_start;
  logic         eng_done;
  logic [27:0]  eng_sum;
  logic [8:0]   eng_len;
  logic [N-1:0] rsp_valid;
  logic [N-1:0] rsp_ready;
  logic [27:0]  rsp_sum;
  logic [8:0]   rsp_len;
  logic         rsp_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vnlp_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .busy        (busy),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .eng_sum     (eng_sum),
    .eng_len     (eng_len),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_sum     (rsp_sum),
    .rsp_len     (rsp_len),
    .rsp_timeout (rsp_timeout)
  );

  typedef struct {
    logic [3:0]  req;
    logic        keep;
    int          done_cyc;   // WAIT cycle (1-based) carrying eng_done, 0 = never
    logic [27:0] sum;
    logic [8:0]  len;
    int          ready_wait;
    logic [3:0]  exp_grant;
    logic        exp_to;
    logic [27:0] exp_sum;
    logic [8:0]  exp_len;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_start"}, 32'(eng_start), 0);
    chk({tag, "_valid"}, 32'(rsp_valid), 0);
  endtask

  // One complete job; called at a negedge with the arbiter idle.
  task automatic do_job(input vec_t v);
    int lat;
    int k;
    int exp_k;
    logic seen;
    logic [3:0] stray;
    req = v.req;
    lat = 0;
    while (!eng_start && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    chk("start_latency", 32'(lat), 1);
    chk("grant", 32'(grant), 32'(v.exp_grant));
    chk("busy_start", 32'(busy), 1);

    k = 0;
    seen = 1'b0;
    while (!seen && k < int'(TO) + 3) begin
      @(negedge clk);
      k++;
      if (rsp_valid != '0) seen = 1'b1;
      else begin
        chk("no_restart_in_wait", 32'(eng_start), 0);
        eng_done = (k == v.done_cyc);
        eng_sum  = v.sum;
        eng_len  = v.len;
      end
    end
    exp_k = (v.done_cyc >= 1 && v.done_cyc <= int'(TO)) ? v.done_cyc + 1 : int'(TO) + 1;
    chk("resp_latency", 32'(k), 32'(exp_k));
    chk("rsp_valid", 32'(rsp_valid), 32'(v.exp_grant));
    chk("rsp_sum", 32'(rsp_sum), 32'(v.exp_sum));
    chk("rsp_len", 32'(rsp_len), 32'(v.exp_len));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_to));
    eng_done = 1'b0;

    // Backpressure with stray ready bits and spurious engine completions.
    for (int w = 0; w < v.ready_wait; w++) begin
      stray     = 4'($urandom);
      rsp_ready = stray & ~v.exp_grant;
      eng_done  = (w % 3 == 1);
      eng_sum   = 28'($urandom);
      eng_len   = 9'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'(v.exp_grant));
      chk("hold_sum", 32'(rsp_sum), 32'(v.exp_sum));
      chk("hold_len", 32'(rsp_len), 32'(v.exp_len));
      chk("hold_timeout", 32'(rsp_timeout), 32'(v.exp_to));
      chk("hold_no_start", 32'(eng_start), 0);
    end
    eng_done  = 1'b0;
    rsp_ready = v.exp_grant;
    if (!v.keep) req = '0;
    @(negedge clk);
    rsp_ready = '0;
    check_idle("after_handshake");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset_sum", 32'(rsp_sum), 0);
    chk("reset_len", 32'(rsp_len), 0);
    chk("reset_timeout", 32'(rsp_timeout), 0);
    reset = 1'b0;
  endtask

  vec_t tbl[11];
  vec_t v;
  int   m_ptr;
  int   owner;
  int   dc;

  initial begin
    reset = 1'b1; req = '0; eng_done = 1'b0; eng_sum = '0; eng_len = '0; rsp_ready = '0;

    tbl[0]  = '{4'b1111, 1'b1, 1, 28'h11, 9'd1, 0, 4'b0001, 1'b0, 28'h11, 9'd1};
    tbl[1]  = '{4'b1111, 1'b1, 2, 28'h22, 9'd2, 0, 4'b0010, 1'b0, 28'h22, 9'd2};
    tbl[2]  = '{4'b1111, 1'b1, 3, 28'h33, 9'd3, 0, 4'b0100, 1'b0, 28'h33, 9'd3};
    tbl[3]  = '{4'b1111, 1'b1, 1, 28'h44, 9'd4, 0, 4'b1000, 1'b0, 28'h44, 9'd4};
    tbl[4]  = '{4'b1111, 1'b0, 4, 28'h55, 9'd5, 0, 4'b0001, 1'b0, 28'h55, 9'd5};
    tbl[5]  = '{4'b0001, 1'b0, 5, 28'h0000123, 9'd17, 0, 4'b0001, 1'b0, 28'h0000123, 9'd17};
    tbl[6]  = '{4'b0100, 1'b0, 0, 28'hABC, 9'd5, 0, 4'b0100, 1'b1, 28'h0, 9'd0};
    tbl[7]  = '{4'b0100, 1'b0, 8, 28'd42, 9'd3, 0, 4'b0100, 1'b0, 28'd42, 9'd3};
    tbl[8]  = '{4'b1010, 1'b0, 7, 28'hFFFFFFF, 9'h1FF, 2, 4'b1000, 1'b0, 28'hFFFFFFF, 9'h1FF};
    tbl[9]  = '{4'b1010, 1'b0, 9, 28'h55, 9'd6, 0, 4'b0010, 1'b1, 28'h0, 9'd0};
    tbl[10] = '{4'b0001, 1'b0, 3, 28'h77, 9'd7, 10, 4'b0001, 1'b0, 28'h77, 9'd7};

    repeat (3) @(negedge clk);
    check_idle("initial_reset");
    chk("initial_sum", 32'(rsp_sum), 0);
    chk("initial_timeout", 32'(rsp_timeout), 0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) do_job(tbl[i]);

    // Reset two cycles after eng_start; pointer is 1 going in.
    req = 4'b0001;
    @(negedge clk);
    chk("rst_job_start", 32'(eng_start), 1);
    chk("rst_job_grant", 32'(grant), 32'(4'b0001));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset    = 1'b0;
    eng_done = 1'b1;
    eng_sum  = 28'h999;
    eng_len  = 9'd9;
    check_idle("mid_wait_reset");
    chk("mid_wait_reset_sum", 32'(rsp_sum), 0);
    chk("mid_wait_reset_len", 32'(rsp_len), 0);
    chk("mid_wait_reset_to", 32'(rsp_timeout), 0);
    @(negedge clk);
    eng_done = 1'b0;
    check_idle("late_done_ignored");
    chk("late_done_sum", 32'(rsp_sum), 0);
    // Pointer back at 0: 0011 must pick requester 0.
    v = '{4'b0011, 1'b0, 2, 28'h31, 9'd4, 0, 4'b0001, 1'b0, 28'h31, 9'd4};
    do_job(v);
    v = '{4'b0010, 1'b0, 1, 28'h32, 9'd5, 0, 4'b0010, 1'b0, 28'h32, 9'd5};
    do_job(v);

    // Randomized jobs against a round-robin / timeout model.
    do_reset();
    m_ptr = 0;
    for (int j = 0; j < 30; j++) begin
      v.req  = 4'($urandom_range(1, 15));
      v.keep = 1'b0;
      dc     = int'($urandom_range(0, 10));
      v.done_cyc   = dc;
      v.sum        = 28'($urandom);
      v.len        = 9'($urandom);
      v.ready_wait = int'($urandom_range(0, 3));
      owner = -1;
      for (int i = 0; i < int'(N); i++) begin
        if (owner < 0 && v.req[(m_ptr + i) % int'(N)]) owner = (m_ptr + i) % int'(N);
      end
      v.exp_grant = 4'(1 << owner);
      if (dc >= 1 && dc <= int'(TO)) begin
        v.exp_to  = 1'b0;
        v.exp_sum = v.sum;
        v.exp_len = v.len;
      end else begin
        v.exp_to  = 1'b1;
        v.exp_sum = '0;
        v.exp_len = '0;
      end
      do_job(v);
      m_ptr = (owner + 1) % int'(N);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vnlp_arbiter.md
VNLP_ARBITER -- requirements
Module: vnlp_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one VNLP engine.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles to wait for eng_done before abort; legal range 2..2047.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester job request, level, held until the response handshake completes.
REQ-006 grant  output  N_REQ  one-hot owner of the engine, all-zero when idle.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 eng_start  output  1  one-cycle start pulse to the engine.
REQ-009 eng_done  input  1  engine completion, sampled only in WAIT.
REQ-010 eng_sum  input  28  engine Sum result.
REQ-011 eng_len  input  9  engine Len result.
REQ-012 rsp_valid  output  N_REQ  one-hot response valid to the granted requester.
REQ-013 rsp_ready  input  N_REQ  per-requester response accept.
REQ-014 rsp_sum  output  28  registered result sum, shared bus.
REQ-015 rsp_len  output  9  registered result length, shared bus.
REQ-016 rsp_timeout  output  1  high with rsp_valid when the job aborted on timeout.

Function
REQ-017 FSM states: IDLE, START, WAIT, RESP; state, grant, pointer, timer, and all outputs registered.
REQ-018 IDLE: if req nonzero, select the first asserted requester searching from index ptr upward with wrap-around modulo N_REQ; load grant one-hot; go START next cycle. If req is zero, stay in IDLE.
REQ-019 START: eng_start=1 for exactly this cycle; timer cleared to 0; go WAIT.
REQ-020 WAIT: timer increments each cycle. If eng_done=1, capture eng_sum/eng_len into rsp_sum/rsp_len, rsp_timeout=0, go RESP.
REQ-021 WAIT: if timer==TIMEOUT-1 and eng_done=0, set rsp_sum=0, rsp_len=0, rsp_timeout=1, go RESP.
REQ-022 eng_done and timeout expiry in the same cycle: done wins and the result is captured normally.
REQ-023 eng_done outside WAIT is ignored and SHALL NOT change state or result registers.
REQ-024 RESP: rsp_valid = grant. When rsp_ready is high at the granted index, the handshake completes: ptr := granted index + 1 (mod N_REQ), grant := 0, rsp_valid := 0, go IDLE.
REQ-025 rsp_ready bits at non-granted indices are ignored.
REQ-026 Request deasserted after grant: the job still runs to completion/timeout and the response is still offered; the arbiter waits in RESP until rsp_ready.
REQ-027 Latency: request seen in IDLE at cycle t -> grant at t+1, eng_start at t+1 (START), earliest rsp_valid at t+3 if eng_done arrives at t+2.
REQ-028 Minimum gap between eng_start pulses: 4 cycles; at most one job in flight.
REQ-029 rsp_sum/rsp_len/rsp_timeout hold their value from capture until the next capture.

Reset
REQ-030 reset=1 in any state, including mid-WAIT or mid-RESP, SHALL force at the next edge: state=IDLE, ptr=0, timer=0, grant=0, rsp_valid=0, eng_start=0, busy=0, rsp_sum=0, rsp_len=0, rsp_timeout=0.
REQ-031 A job aborted by reset is not reported; a later eng_done from the engine is ignored (REQ-023).

Verification
REQ-032 Single job: req=0001, eng_done 5 cycles after eng_start with sum=0x0000123, len=17 -> one eng_start pulse, rsp_valid=0001, rsp_sum=0x0000123, rsp_len=17, rsp_timeout=0; rsp_ready[0] -> IDLE, grant=0.
REQ-033 Round-robin fairness: req=1111 held continuously, engine answers every job -> grant order 0001,0010,0100,1000,0001; no requester served twice before all others.
REQ-034 Timeout: TIMEOUT=8, req=0100, eng_done never asserted -> rsp_valid=0100 exactly 8 cycles after entering WAIT with rsp_sum=0, rsp_len=0, rsp_timeout=1.
REQ-035 Done/timeout race: TIMEOUT=8, eng_done on the 8th WAIT cycle with sum=42, len=3 -> rsp_timeout=0, rsp_sum=42, rsp_len=3.
REQ-036 Backpressure and stray inputs: rsp_ready held 0 for 10 cycles and rsp_ready[3] toggled while grant=0001, spurious eng_done in RESP -> rsp_valid stays 0001, result unchanged, no new eng_start until rsp_ready[0].
REQ-037 Reset mid-WAIT: assert reset 2 cycles after eng_start, then eng_done -> all outputs at reset values, no rsp_valid, next req=0010 granted with ptr=0 search order.
